// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter (with internal 3-bit ALU)
//  Description : Round-robin arbiter sharing one 3-bit ALU between two
//                requesters; one operation in flight, registered results.
//                Optional saturating overflow counter: ALU_ARB_OVF_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Op select: Sel[2]=0 arithmetic {00 A+B, 01 A-B, 10 A+1, 11 A-1},
//            Sel[2]=1 logic      {00 A&B, 01 A|B, 10 A^B, 11 ~A}.
module ALU (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic [2:0] Sel,
  output logic [2:0] Out,
  output logic       Zero,
  output logic       C_Out,
  output logic       Overflow,
  output logic       Negative
);

  logic [2:0] w_op_b;
  logic       w_cin;
  logic [3:0] w_sum;

  // All arithmetic ops share one adder: A + op_b + cin.
  always_comb begin
    w_op_b = B;
    w_cin  = 1'b0;
    case (Sel[1:0])
      2'b00:   begin w_op_b = B;      w_cin = 1'b0; end
      2'b01:   begin w_op_b = ~B;     w_cin = 1'b1; end
      2'b10:   begin w_op_b = 3'b000; w_cin = 1'b1; end
      default: begin w_op_b = 3'b111; w_cin = 1'b0; end
    endcase
  end

  assign w_sum = {1'b0, A} + {1'b0, w_op_b} + {3'b000, w_cin};

  always_comb begin
    Out      = w_sum[2:0];
    C_Out    = 1'b0;
    Overflow = 1'b0;
    if (!Sel[2]) begin
      Out      = w_sum[2:0];
      C_Out    = w_sum[3];
      Overflow = (A[2] == w_op_b[2]) && (w_sum[2] != A[2]);
    end else begin
      case (Sel[1:0])
        2'b00:   Out = A & B;
        2'b01:   Out = A | B;
        2'b10:   Out = A ^ B;
        default: Out = ~A;
      endcase
    end
  end

  assign Zero     = (Out == 3'b000);
  assign Negative = Out[2];

endmodule

module alu_arbiter #(
  parameter int WIDTH      = 3,
  parameter int SEL_W      = 3,
  parameter int FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [SEL_W-1:0] s0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [SEL_W-1:0] s1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             overflow,
  output logic             negative,
  output logic             busy
`ifdef ALU_ARB_OVF_COUNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  generate
    if (WIDTH != 3 || SEL_W != 3) begin : g_width_check
      $error("alu_arbiter: WIDTH and SEL_W are fixed to 3");
    end
    if (FIRST_PRIO != 0 && FIRST_PRIO != 1) begin : g_prio_check
      $error("alu_arbiter: FIRST_PRIO must be 0 or 1");
    end
  endgenerate

  localparam logic c_first_prio = (FIRST_PRIO != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_launch;
  logic             w_capture;
  logic             w_pick;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [SEL_W-1:0] r_s;
  logic             r_winner;
  logic             r_last_served;

  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_c_out;
  logic             r_overflow;
  logic             r_negative;

  logic [2:0]       w_alu_out;
  logic             w_alu_zero;
  logic             w_alu_c_out;
  logic             w_alu_ovf;
  logic             w_alu_neg;

  // ALU only ever sees the latched operands, never the live request inputs.
  ALU u_alu (
    .A        (r_a),
    .B        (r_b),
    .Sel      (r_s),
    .Out      (w_alu_out),
    .Zero     (w_alu_zero),
    .C_Out    (w_alu_c_out),
    .Overflow (w_alu_ovf),
    .Negative (w_alu_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_capture    = 1'b0;
    w_pick       = r_winner;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_launch     = 1'b1;
          w_next_state = ST_EXEC;
          // Under contention the requester not served last time wins.
          if (req0 && req1) w_pick = ~r_last_served;
          else              w_pick = req1;
        end
      end
      ST_EXEC: begin
        w_capture    = 1'b1;
        w_next_state = ST_RESP;
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_s           <= '0;
      r_winner      <= 1'b0;
      r_last_served <= ~c_first_prio;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_c_out       <= 1'b0;
      r_overflow    <= 1'b0;
      r_negative    <= 1'b0;
    end else begin
      r_gnt0  <= w_launch & ~w_pick;
      r_gnt1  <= w_launch &  w_pick;
      r_done0 <= w_capture & ~r_winner;
      r_done1 <= w_capture &  r_winner;
      if (w_launch) begin
        r_winner <= w_pick;
        r_a      <= w_pick ? a1 : a0;
        r_b      <= w_pick ? b1 : b0;
        r_s      <= w_pick ? s1 : s0;
      end
      if (w_capture) begin
        r_last_served <= r_winner;
        r_result      <= w_alu_out;
        r_zero        <= w_alu_zero;
        r_c_out       <= w_alu_c_out;
        r_overflow    <= w_alu_ovf;
        r_negative    <= w_alu_neg;
      end
    end
  end

`ifdef ALU_ARB_OVF_COUNT_EN
  logic [7:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_ovf_count <= 8'd0;
    else if (w_capture && w_alu_ovf && (r_ovf_count != 8'hFF))
      r_ovf_count <= r_ovf_count + 8'd1;
  end

  assign ovf_count = r_ovf_count;
`endif

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign result   = r_result;
  assign zero     = r_zero;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;
  assign negative = r_negative;
  assign busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire
